// File: rtl/alu_mdu_if.sv
// Request/response bundle for alu_mdu: operation request with handshake in,
// registered result with handshake out.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 31
);
    logic              i_valid;
    logic              o_ready;
    logic [6:0]        i_opcode;
    logic [6:0]        i_funct7;
    logic [2:0]        i_funct3;
    logic [DATA_WIDTH:0] i_rs1_data;
    logic [DATA_WIDTH:0] i_rs2_data;
    logic [31:0]       i_imm;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_WIDTH:0] o_rd_data;
    logic              o_busy;

    modport master (
        output i_valid, i_opcode, i_funct7, i_funct3, i_rs1_data, i_rs2_data, i_imm, i_ready,
        input  o_ready, o_valid, o_rd_data, o_busy
    );

    modport slave (
        input  i_valid, i_opcode, i_funct7, i_funct3, i_rs1_data, i_rs2_data, i_imm, i_ready,
        output o_ready, o_valid, o_rd_data, o_busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Sequential RV32I ALU with iterative radix-2 RV32M multiply/divide engines.
// The M-extension is built only when the macro ALU_MDU_M_EXT_EN is defined.
module alu_mdu #(
    parameter int DATA_WIDTH = 31
) (
    input  logic     clk,
    input  logic     clk_en,
    input  logic     rst,
    alu_mdu_if.slave bus
);
    localparam int XLEN = DATA_WIDTH + 1;
    localparam int SHW  = $clog2(XLEN);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            is_m;

    function automatic logic [XLEN-1:0] base_result(
        input logic [6:0]      opc,
        input logic [6:0]      f7,
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] rs2,
        input logic [31:0]     imm
    );
        logic [XLEN-1:0]        b;
        logic [SHW-1:0]         sh;
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [XLEN-1:0]        r;
        b  = (opc == OPC_OP) ? rs2 : XLEN'($signed(imm));
        sh = b[SHW-1:0];
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b000:  r = (opc == OPC_OP && f7[5]) ? a - b : a + b;
            3'b001:  r = a << sh;
            3'b010:  r = {{(XLEN-1){1'b0}}, sa < sb};
            3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = f7[5] ? $unsigned(sa >>> sh) : a >> sh;
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        if (opc != OPC_OP && opc != OPC_IMM) begin
            r = '0;
        end
        return r;
    endfunction

    assign is_m = (bus.i_opcode == OPC_OP) && (bus.i_funct7 == 7'h01);

`ifdef ALU_MDU_M_EXT_EN
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam int         CW   = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_prod;
    logic [XLEN:0]     div_rs, div_diff;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   div_res;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic en);
        return (en && x[XLEN-1]) ? -x : x;
    endfunction

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both, MUL treated unsigned.
    assign a_sgn = bus.i_funct3[2] ? !bus.i_funct3[0]
                                   : (bus.i_funct3[1:0] == 2'b01 || bus.i_funct3[1:0] == 2'b10);
    assign b_sgn = bus.i_funct3[2] ? !bus.i_funct3[0] : (bus.i_funct3[1:0] == 2'b01);
    assign a_neg = a_sgn && bus.i_rs1_data[XLEN-1];
    assign b_neg = b_sgn && bus.i_rs2_data[XLEN-1];

    // Shift-add: acc holds {partial high, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_step : mul_step;

    // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}.
    assign div_rs   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rs - {1'b0, opb_q};
    assign div_step = div_diff[XLEN] ? {div_rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign div_res  = f3_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
`ifdef ALU_MDU_M_EXT_EN
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    state_d = DONE;
                    if (is_m) begin
`ifdef ALU_MDU_M_EXT_EN
                        cnt_d = '0;
                        f3_d  = bus.i_funct3;
                        opb_d = mag(bus.i_rs2_data, b_sgn);
                        acc_d = {{XLEN{1'b0}}, mag(bus.i_rs1_data, a_sgn)};
                        neg_d = (bus.i_funct3[2] && bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        if (!bus.i_funct3[2]) begin
                            state_d = MUL;
                        end else if (bus.i_rs2_data == '0) begin
                            rd_d = bus.i_funct3[1] ? bus.i_rs1_data : '1;
                        end else if (!bus.i_funct3[0] && bus.i_rs2_data == '1 &&
                                     bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) begin
                            rd_d = bus.i_funct3[1] ? '0 : bus.i_rs1_data;
                        end else begin
                            state_d = DIV;
                        end
`else
                        rd_d = '0;
`endif
                    end else begin
                        rd_d = base_result(bus.i_opcode, bus.i_funct7, bus.i_funct3,
                                           bus.i_rs1_data, bus.i_rs2_data, bus.i_imm);
                    end
                end
            end
`ifdef ALU_MDU_M_EXT_EN
            MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    rd_d    = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    rd_d    = neg_q ? -div_res : div_res;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
`ifdef ALU_MDU_M_EXT_EN
            cnt_q   <= '0;
`endif
        end else if (clk_en) begin
            state_q <= state_d;
            rd_q    <= rd_d;
`ifdef ALU_MDU_M_EXT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef ALU_MDU_M_EXT_EN
    always_ff @(posedge clk) begin
        if (clk_en) begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            f3_q  <= f3_d;
            neg_q <= neg_d;
        end
    end

    assign bus.o_busy = (state_q == MUL) || (state_q == DIV);
`else
    assign bus.o_busy = 1'b0;
`endif

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_valid   = (state_q == DONE);
    assign bus.o_rd_data = rd_q;
endmodule
